// File: rtl/fb_write_arbiter_pkg.sv
// rtl/fb_write_arbiter_pkg.sv - shared framebuffer geometry, colours and arbiter state type
package fb_write_arbiter_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int FB_SIZE_DEF = SCREEN_W * SCREEN_H;
  localparam int AW_DEF      = 19;
  localparam int DW_DEF      = 12;

  // RGB444 colours used by the game renderers
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_BLUE  = 12'h00F;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Linear pixel address of screen coordinate (x, y)
  function automatic int xy_to_addr(input int x, input int y);
    return y * SCREEN_W + x;
  endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_priority_picker.sv
// rtl/fb_write_arbiter_rr_priority_picker.sv - round-robin pick of the first request after rr_ptr
module rr_priority_picker #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   rr_ptr,
  output logic [GW-1:0]   grant,
  output logic            any
);

  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] masked;
  logic              found;

  // Keep the window rr_ptr+1 .. rr_ptr+NREQ of the doubled vector, then take its lowest set bit
  always_comb begin
    req_dbl = {req, req};
    masked  = '0;
    grant   = '0;
    found   = 1'b0;
    for (int j = 0; j < 2 * NREQ; j++) begin
      masked[j] = req_dbl[j] && (j > int'(rr_ptr)) && (j <= int'(rr_ptr) + NREQ);
    end
    for (int j = 0; j < 2 * NREQ; j++) begin
      if (!found && masked[j]) begin
        found = 1'b1;
        grant = GW'(j % NREQ);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin burst arbiter for the framebuffer pixel write port
module fb_write_arbiter
  import fb_write_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int FB_SIZE  = FB_SIZE_DEF,
  parameter int MAX_IDLE = 15,
  parameter int GW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_allow,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     mem_px_addr,
  output logic [DW-1:0]     mem_px_data,
  output logic              px_wr,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              err_oob
);

  localparam int IW = (MAX_IDLE < 1) ? 1 : $clog2(MAX_IDLE + 1);
  localparam logic [AW-1:0] FB_LIMIT = AW'(FB_SIZE);
  localparam logic [IW-1:0] IDLE_MAX = IW'(MAX_IDLE);
  localparam logic [GW-1:0] PTR_RST  = GW'(NREQ - 1);

  arb_state_e     state_q, state_d;
  logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]  grant_id_q, grant_id_d;
  logic [IW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [AW-1:0]  mem_px_addr_q, mem_px_addr_d;
  logic [DW-1:0]  mem_px_data_q, mem_px_data_d;
  logic           px_wr_q, px_wr_d;
  logic           err_oob_q, err_oob_d;

  logic [GW-1:0]  pick_id;
  logic           pick_any;
  logic           sel_valid;
  logic           sel_last;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_data;
  logic           xfer;

  rr_priority_picker #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_id),
    .any    (pick_any)
  );

  // Route the current owner's request lines to a single beat
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Only the owner sees ready, and only while the port is open and it is presenting a beat
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == ST_GRANT) && (grant_id_q == GW'(i)) && wr_allow && req_valid[i];
    end
  end

  assign xfer = (state_q == ST_GRANT) && wr_allow && sel_valid;

  // Arbitration, burst tracking, idle timeout and write-port register updates
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    idle_cnt_d    = idle_cnt_q;
    mem_px_addr_d = mem_px_addr_q;
    mem_px_data_d = mem_px_data_q;
    px_wr_d       = 1'b0;
    err_oob_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d = pick_id;
          idle_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer) begin
          idle_cnt_d = '0;
          if (sel_addr < FB_LIMIT) begin
            px_wr_d       = 1'b1;
            mem_px_addr_d = sel_addr;
            mem_px_data_d = sel_data;
          end else begin
            err_oob_d = 1'b1;
          end
          if (sel_last) begin
            rr_ptr_d = grant_id_q;
            state_d  = ST_IDLE;
          end
        end else if (wr_allow) begin
          // A stalled port never counts against the owner; a silent owner does
          if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
          if (idle_cnt_d == IDLE_MAX) begin
            idle_cnt_d = '0;
            rr_ptr_d   = grant_id_q;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also aborts any burst in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= PTR_RST;
      grant_id_q    <= '0;
      idle_cnt_q    <= '0;
      mem_px_addr_q <= '0;
      mem_px_data_q <= '0;
      px_wr_q       <= 1'b0;
      err_oob_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      idle_cnt_q    <= idle_cnt_d;
      mem_px_addr_q <= mem_px_addr_d;
      mem_px_data_q <= mem_px_data_d;
      px_wr_q       <= px_wr_d;
      err_oob_q     <= err_oob_d;
    end
  end

  assign mem_px_addr = mem_px_addr_q;
  assign mem_px_data = mem_px_data_q;
  assign px_wr       = px_wr_q;
  assign err_oob     = err_oob_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - scoreboard bench for fb_write_arbiter
module tb_fb_write_arbiter;
  import fb_write_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 19;
  localparam int DW   = 12;
  localparam int GW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wr_allow = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        mem_px_addr;
  logic [DW-1:0]        mem_px_data;
  logic                 px_wr;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 err_oob;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            oob;
  } exp_t;

  exp_t exp_q[$];
  int   wr_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;

  fb_write_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .FB_SIZE(FB_SIZE_DEF), .MAX_IDLE(15), .GW(GW)
  ) dut (
    .clk(clk), .rst(rst), .wr_allow(wr_allow),
    .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data),
    .px_wr(px_wr), .grant_id(grant_id), .busy(busy), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit oob);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.oob  = oob;
    exp_q.push_back(e);
  endtask

  // Monitor: every write-port event is matched against the next expected beat
  always @(negedge clk) begin : monitor
    exp_t e;
    if (px_wr || err_oob) begin
      if (px_wr) wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: px_wr=%0d err_oob=%0d addr=%0h data=%0h with nothing expected",
                 px_wr, err_oob, mem_px_addr, mem_px_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_px_wr",  32'(px_wr),       32'(!e.oob));
        check("sb_err_oob", 32'(err_oob),    32'(e.oob));
        check("sb_addr",   32'(mem_px_addr), 32'(e.addr));
        check("sb_data",   32'(mem_px_data), 32'(e.data));
      end
    end
  end

  // One requester issuing an n-beat burst at consecutive addresses; starts and ends on a negedge
  task automatic drive_burst(input int id, input int n, input logic [AW-1:0] a0, input logic [DW-1:0] d);
    bit done;
    int waitc;
    for (int b = 0; b < n; b++) begin
      req_valid[id] = 1'b1;
      req_last[id]  = (b == n - 1);
      req_addr[id*AW +: AW] = a0 + AW'(b);
      req_data[id*DW +: DW] = d;
      done  = 1'b0;
      waitc = 0;
      while (!done && waitc < 200) begin
        #1;
        done = req_ready[id];
        @(negedge clk);
        waitc++;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL drv_timeout: requester %0d beat %0d got ready=%0d required 1", id, b, req_ready[id]);
        break;
      end
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",     32'(busy),        32'd0);
    check("rst_px_wr",    32'(px_wr),       32'd0);
    check("rst_err_oob",  32'(err_oob),     32'd0);
    check("rst_grant_id", 32'(grant_id),    32'd0);
    check("rst_addr",     32'(mem_px_addr), 32'd0);
    check("rst_data",     32'(mem_px_data), 32'd0);
    check("rst_ready",    32'(req_ready),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single writer 0, three beats
    push_exp(19'd0, COLOR_WHITE, 1'b0);
    push_exp(19'd1, COLOR_WHITE, 1'b0);
    push_exp(19'd2, COLOR_WHITE, 1'b0);
    wr_cyc.delete();
    t0 = cyc;
    drive_burst(0, 3, 19'd0, COLOR_WHITE);
    #1;
    check("t1_busy_drop", 32'(busy), 32'd0);
    check("t1_wr_count",  32'(wr_cyc.size()), 32'd3);
    for (int i = 0; i < wr_cyc.size() && i < 3; i++)
      check("t1_wr_latency", 32'(wr_cyc[i] - t0), 32'(i + 2));

    // Four requesters held valid: strict round-robin from requester 0
    do_reset();
    push_exp(19'd100, 12'hA00, 1'b0);
    push_exp(19'd101, 12'hA01, 1'b0);
    push_exp(19'd102, 12'hA02, 1'b0);
    push_exp(19'd103, 12'hA03, 1'b0);
    push_exp(19'd200, 12'hB00, 1'b0);
    wr_cyc.delete();
    t0 = cyc;
    fork
      begin
        drive_burst(0, 1, 19'd100, 12'hA00);
        drive_burst(0, 1, 19'd200, 12'hB00);
      end
      drive_burst(1, 1, 19'd101, 12'hA01);
      drive_burst(2, 1, 19'd102, 12'hA02);
      drive_burst(3, 1, 19'd103, 12'hA03);
    join
    #1;
    check("t2_wr_count", 32'(wr_cyc.size()), 32'd5);
    if (wr_cyc.size() > 0) check("t2_first_wr", 32'(wr_cyc[0] - t0), 32'd2);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("t2_wr_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);

    // wr_allow stall mid-burst from requester 2: no ready, no write, no timeout
    for (int b = 0; b < 4; b++) push_exp(19'd300 + 19'(b), 12'h0C0, 1'b0);
    fork
      drive_burst(2, 4, 19'd300, 12'h0C0);
      begin
        repeat (2) @(negedge clk);
        wr_allow = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          #1;
          check("t3_stall_ready", 32'(req_ready), 32'd0);
          check("t3_stall_px_wr", 32'(px_wr),     32'd0);
          check("t3_stall_busy",  32'(busy),      32'd1);
        end
        @(negedge clk);
        wr_allow = 1'b1;
      end
    join

    // Owner 1 goes silent mid-burst; timeout hands the port to pending requester 2
    push_exp(19'd400, 12'h0A0, 1'b0);
    push_exp(19'd500, 12'h0B0, 1'b0);
    fork
      begin
        req_valid[1] = 1'b1;
        req_last[1]  = 1'b0;
        req_addr[1*AW +: AW] = 19'd400;
        req_data[1*DW +: DW] = 12'h0A0;
        @(negedge clk);
        #1;
        check("t4_owner1_ready", 32'(req_ready), 32'b0010);
        check("t4_owner1_gid",   32'(grant_id),  32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (14) @(negedge clk);
        #1;
        check("t4_busy_idle14", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("t4_busy_idle15", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("t4_regrant_busy", 32'(busy),     32'd1);
        check("t4_regrant_gid",  32'(grant_id), 32'd2);
      end
      drive_burst(2, 1, 19'd500, 12'h0B0);
    join

    // Last in-range pixel, then the first out-of-range address
    push_exp(AW'(xy_to_addr(SCREEN_W - 1, SCREEN_H - 1)), COLOR_BLUE, 1'b0);
    push_exp(AW'(xy_to_addr(SCREEN_W - 1, SCREEN_H - 1)), COLOR_BLUE, 1'b1);
    drive_burst(3, 1, AW'(xy_to_addr(SCREEN_W - 1, SCREEN_H - 1)), COLOR_BLUE);
    drive_burst(3, 1, AW'(FB_SIZE_DEF), COLOR_GREEN);
    @(negedge clk);
    #1;
    check("t5_oob_pulse_end", 32'(err_oob),     32'd0);
    check("t5_oob_no_wr",     32'(px_wr),       32'd0);
    check("t5_oob_addr_hold", 32'(mem_px_addr), 32'd307199);

    // Reset during beat 2 of a 5-beat burst
    push_exp(19'd600, 12'h333, 1'b0);
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b0;
    req_addr[0*AW +: AW] = 19'd600;
    req_data[0*DW +: DW] = 12'h333;
    @(negedge clk);
    @(negedge clk);
    req_addr[0*AW +: AW] = 19'd601;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("t6_rst_px_wr", 32'(px_wr),       32'd0);
    check("t6_rst_oob",   32'(err_oob),     32'd0);
    check("t6_rst_busy",  32'(busy),        32'd0);
    check("t6_rst_gid",   32'(grant_id),    32'd0);
    check("t6_rst_addr",  32'(mem_px_addr), 32'd0);
    check("t6_rst_data",  32'(mem_px_data), 32'd0);
    check("t6_rst_ready", 32'(req_ready),   32'd0);
    rst = 1'b0;
    push_exp(19'd700, 12'h333, 1'b0);
    push_exp(19'd800, 12'h444, 1'b0);
    req_last[0] = 1'b1;
    req_addr[0*AW +: AW] = 19'd700;
    req_valid[1] = 1'b1;
    req_last[1]  = 1'b1;
    req_addr[1*AW +: AW] = 19'd800;
    req_data[1*DW +: DW] = 12'h444;
    @(negedge clk);
    #1;
    check("t6_first_busy",  32'(busy),      32'd1);
    check("t6_first_gid",   32'(grant_id),  32'd0);
    check("t6_first_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    @(negedge clk);
    #1;
    check("t6_second_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
